// File: rtl/sdp_bram_bist_pkg.sv
// Shared state encoding, pattern constant and pattern function for the SDP BRAM self-test.
// SDP_BIST_INVERT_PASS_EN adds the inverted-pattern states.
package sdp_bram_bist_pkg;

  localparam logic [19:0] PAT_MASK = 20'h55000;

`ifdef SDP_BIST_INVERT_PASS_EN
  typedef enum logic [2:0] {
    StIdle, StWrite, StRead, StDrain, StDone, StWriteInv, StReadInv, StDrainInv
  } bist_state_e;
`else
  typedef enum logic [2:0] {
    StIdle, StWrite, StRead, StDrain, StDone
  } bist_state_e;
`endif

  // Address-derived pattern in 32-bit arithmetic, masked down to the requested width.
  function automatic logic [31:0] bist_pattern(input logic [31:0]  addr,
                                               input logic [31:0]  offset,
                                               input logic         inv,
                                               input int unsigned  width);
    logic [31:0] v;
    logic [31:0] p;
    v = addr + offset;
    p = v | (v << 20) | {12'h000, PAT_MASK};
    if (inv) p = ~p;
    if (width < 32) p = p & ((32'h1 << width) - 32'h1);
    return p;
  endfunction

endpackage

// File: rtl/sdp_bram_bist_chk.sv
// Read-data checker: tags each read, compares the returned word against the expected pattern,
// keeps a saturating mismatch count and latches the first failing address.
module sdp_bram_bist_chk
  import sdp_bram_bist_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter int unsigned DATA_WIDTH  = 18,
  parameter int unsigned DATA_OFFSET = 0,
  parameter int unsigned CNT_WIDTH   = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  rce,
  input  logic [ADDR_WIDTH-1:0] ra,
  input  logic                  inv,
  input  logic [DATA_WIDTH-1:0] rq,
  output logic [CNT_WIDTH-1:0]  err_cnt,
  output logic [ADDR_WIDTH-1:0] first_err_addr
);

  logic                  tag_vld_q;
  logic                  tag_inv_q;
  logic [ADDR_WIDTH-1:0] tag_addr_q;
  logic                  seen_q;
  logic [CNT_WIDTH-1:0]  err_cnt_q;
  logic [ADDR_WIDTH-1:0] first_q;
  logic [DATA_WIDTH-1:0] expected;
  logic                  mismatch;

  always_comb begin
    expected = DATA_WIDTH'(bist_pattern(32'(tag_addr_q), DATA_OFFSET, tag_inv_q, DATA_WIDTH));
    mismatch = tag_vld_q && (rq != expected);
  end

  // The tag lines up with rq, which the BRAM returns one cycle after rce.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_vld_q  <= 1'b0;
      tag_inv_q  <= 1'b0;
      tag_addr_q <= '0;
    end else begin
      tag_vld_q <= rce && !clear;
      if (rce) begin
        tag_addr_q <= ra;
        tag_inv_q  <= inv;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_q <= '0;
      first_q   <= '0;
      seen_q    <= 1'b0;
    end else if (clear) begin
      err_cnt_q <= '0;
      first_q   <= '0;
      seen_q    <= 1'b0;
    end else if (mismatch) begin
      if (err_cnt_q != '1) err_cnt_q <= err_cnt_q + CNT_WIDTH'(1);
      if (!seen_q) begin
        seen_q  <= 1'b1;
        first_q <= tag_addr_q;
      end
    end
  end

  assign err_cnt        = err_cnt_q;
  assign first_err_addr = first_q;

endmodule

// File: rtl/sdp_bram_bist.sv
// Self-test sequencer for one half of a split simple-dual-port BRAM: write pattern, read back,
// compare. Define SDP_BIST_INVERT_PASS_EN to add a second pass with the inverted pattern.
module sdp_bram_bist
  import sdp_bram_bist_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter int unsigned DATA_WIDTH  = 18,
  parameter int unsigned ADDR_BASE   = 0,
  parameter int unsigned DEPTH       = 512,
  parameter int unsigned DATA_OFFSET = 0,
  parameter int unsigned CNT_WIDTH   = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [CNT_WIDTH-1:0]  err_cnt,
  output logic [ADDR_WIDTH-1:0] first_err_addr,
  output logic                  wce,
  output logic [ADDR_WIDTH-1:0] wa,
  output logic [DATA_WIDTH-1:0] wd,
  output logic                  rce,
  output logic [ADDR_WIDTH-1:0] ra,
  input  logic [DATA_WIDTH-1:0] rq
);

  if ((DEPTH == 0) || ((64'(ADDR_BASE) + 64'(DEPTH)) > (64'd1 << ADDR_WIDTH))) begin : gen_bad_window
    $error("sdp_bram_bist: tested window does not fit the address space");
  end

  localparam logic [ADDR_WIDTH-1:0] BaseAddr = ADDR_WIDTH'(ADDR_BASE);
  localparam logic [ADDR_WIDTH-1:0] LastIdx  = ADDR_WIDTH'(DEPTH - 1);

  bist_state_e           state_q, state_d;
  bist_state_e           read_state, drain_state;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  logic [ADDR_WIDTH-1:0] next_addr;
  logic                  last;
  logic                  wce_q, wce_d;
  logic                  rce_q, rce_d;
  logic [ADDR_WIDTH-1:0] wa_q, wa_d;
  logic [ADDR_WIDTH-1:0] ra_q, ra_d;
  logic [DATA_WIDTH-1:0] wd_q, wd_d;
  logic                  armed_q;
  logic                  clear;
  logic                  inv;

  function automatic logic [DATA_WIDTH-1:0] pat(input logic [ADDR_WIDTH-1:0] a, input logic i);
    return DATA_WIDTH'(bist_pattern(32'(a), DATA_OFFSET, i, DATA_WIDTH));
  endfunction

`ifdef SDP_BIST_INVERT_PASS_EN
  logic inv_q, inv_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) inv_q <= 1'b0;
    else        inv_q <= inv_d;
  end

  assign inv = inv_q;
`else
  assign inv = 1'b0;
`endif

  // A start on the first edge after reset release is not trusted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) armed_q <= 1'b0;
    else        armed_q <= 1'b1;
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    wce_d     = 1'b0;
    rce_d     = 1'b0;
    wa_d      = wa_q;
    wd_d      = wd_q;
    ra_d      = ra_q;
    clear     = 1'b0;
    next_addr = BaseAddr + idx_q + ADDR_WIDTH'(1);
    last      = (idx_q == LastIdx);
`ifdef SDP_BIST_INVERT_PASS_EN
    inv_d       = inv_q;
    read_state  = inv_q ? StReadInv : StRead;
    drain_state = inv_q ? StDrainInv : StDrain;
`else
    read_state  = StRead;
    drain_state = StDrain;
`endif

    unique case (state_q)
      StIdle, StDone: begin
        if (start && armed_q) begin
          state_d = StWrite;
          idx_d   = '0;
          clear   = 1'b1;
          wce_d   = 1'b1;
          wa_d    = BaseAddr;
          wd_d    = pat(BaseAddr, 1'b0);
`ifdef SDP_BIST_INVERT_PASS_EN
          inv_d   = 1'b0;
`endif
        end
      end
`ifdef SDP_BIST_INVERT_PASS_EN
      StWrite, StWriteInv: begin
`else
      StWrite: begin
`endif
        if (last) begin
          state_d = read_state;
          idx_d   = '0;
          rce_d   = 1'b1;
          ra_d    = BaseAddr;
        end else begin
          idx_d = idx_q + ADDR_WIDTH'(1);
          wce_d = 1'b1;
          wa_d  = next_addr;
          wd_d  = pat(next_addr, inv);
        end
      end
`ifdef SDP_BIST_INVERT_PASS_EN
      StRead, StReadInv: begin
`else
      StRead: begin
`endif
        if (last) begin
          state_d = drain_state;
        end else begin
          idx_d = idx_q + ADDR_WIDTH'(1);
          rce_d = 1'b1;
          ra_d  = next_addr;
        end
      end
      StDrain: begin
`ifdef SDP_BIST_INVERT_PASS_EN
        state_d = StWriteInv;
        idx_d   = '0;
        inv_d   = 1'b1;
        wce_d   = 1'b1;
        wa_d    = BaseAddr;
        wd_d    = pat(BaseAddr, 1'b1);
`else
        state_d = StDone;
`endif
      end
`ifdef SDP_BIST_INVERT_PASS_EN
      StDrainInv: state_d = StDone;
`endif
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      idx_q   <= '0;
      wce_q   <= 1'b0;
      rce_q   <= 1'b0;
      wa_q    <= '0;
      wd_q    <= '0;
      ra_q    <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      wce_q   <= wce_d;
      rce_q   <= rce_d;
      wa_q    <= wa_d;
      wd_q    <= wd_d;
      ra_q    <= ra_d;
    end
  end

  sdp_bram_bist_chk #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .DATA_OFFSET(DATA_OFFSET),
    .CNT_WIDTH  (CNT_WIDTH)
  ) u_chk (
    .clk           (clk),
    .rst_n         (rst_n),
    .clear         (clear),
    .rce           (rce_q),
    .ra            (ra_q),
    .inv           (inv),
    .rq            (rq),
    .err_cnt       (err_cnt),
    .first_err_addr(first_err_addr)
  );

  assign wce  = wce_q;
  assign wa   = wa_q;
  assign wd   = wd_q;
  assign rce  = rce_q;
  assign ra   = ra_q;
  assign done = (state_q == StDone);
  assign busy = (state_q != StIdle) && (state_q != StDone);
  assign pass = done && (err_cnt == '0);

endmodule

// File: tb/tb_sdp_bram_bist.sv
// Scoreboard bench for sdp_bram_bist: two instances (default window and an offset, narrow,
// saturating one) against behavioural memories with injected bit faults.
module tb_sdp_bram_bist;

  localparam int AW    = 10;
  localparam int DW    = 18;
  localparam int DEPTH = 512;
  localparam int CW    = 16;
  localparam int BDW   = 16;
  localparam int BCW   = 8;
  localparam int BBASE = 512;
`ifdef SDP_BIST_INVERT_PASS_EN
  localparam int PASSES = 2;
`else
  localparam int PASSES = 1;
`endif
  localparam int RUN_CYC = PASSES * (2 * DEPTH + 1) + 1;

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  typedef struct {
    int cnt;
    int first;
    bit pass;
    int start_cyc;
  } res_t;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic           b_start = 1'b0;
  int             cyc = 0;
  int             vectors = 0;
  int             errors = 0;

  logic           a_busy, a_done, a_pass, a_wce, a_rce;
  logic [CW-1:0]  a_err;
  logic [AW-1:0]  a_first, a_wa, a_ra;
  logic [DW-1:0]  a_wd, a_rq;
  logic           b_busy, b_done, b_pass, b_wce, b_rce;
  logic [BCW-1:0] b_err;
  logic [AW-1:0]  b_first, b_wa, b_ra;
  logic [BDW-1:0] b_wd, b_rq;

  logic [DW-1:0]  mem_a  [1024];
  logic [DW-1:0]  flip_a [1024];
  logic [BDW-1:0] mem_b  [1024];

  wr_t            exp_w[$];
  logic [AW-1:0]  exp_r[$];
  res_t           exp_res[$];
  wr_t            exp_bw[$];
  res_t           exp_bres[$];

  sdp_bram_bist u_dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(a_busy), .done(a_done), .pass(a_pass),
    .err_cnt(a_err), .first_err_addr(a_first), .wce(a_wce), .wa(a_wa), .wd(a_wd),
    .rce(a_rce), .ra(a_ra), .rq(a_rq)
  );

  sdp_bram_bist #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(BDW), .ADDR_BASE(BBASE), .DEPTH(DEPTH),
    .DATA_OFFSET(1), .CNT_WIDTH(BCW)
  ) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start(b_start), .busy(b_busy), .done(b_done), .pass(b_pass),
    .err_cnt(b_err), .first_err_addr(b_first), .wce(b_wce), .wa(b_wa), .wd(b_wd),
    .rce(b_rce), .ra(b_ra), .rq(b_rq)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Ideal 1-cycle memories; A returns stored data XOR a per-address fault mask, B always corrupts.
  always @(posedge clk) begin
    if (a_wce) mem_a[a_wa] <= a_wd;
    if (a_rce) a_rq <= mem_a[a_ra] ^ flip_a[a_ra];
    if (b_wce) mem_b[b_wa] <= b_wd;
    if (b_rce) b_rq <= mem_b[b_ra] ^ 16'h0001;
  end

  function automatic logic [31:0] ref_pat(int unsigned a, int unsigned off, bit inv);
    int unsigned v;
    int unsigned p;
    v = a + off;
    p = v | (v << 20) | 32'h55000;
    return inv ? ~p : p;
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  initial begin : mon_a
    wr_t           e;
    res_t          r;
    logic [AW-1:0] ea;
    bit            done_prev;
    done_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_w.delete();
        exp_r.delete();
        exp_res.delete();
        done_prev = 1'b0;
      end else begin
        if (a_wce && a_rce) check("wce_rce_exclusive", 1, 0);
        if (a_wce) begin
          if (exp_w.size() == 0) check("unexpected_write", 1, 0);
          else begin
            e = exp_w.pop_front();
            check("write_addr", a_wa, e.a);
            check("write_data", a_wd, e.d);
            check("busy_in_run", a_busy, 1);
          end
        end
        if (a_rce) begin
          if (exp_r.size() == 0) check("unexpected_read", 1, 0);
          else begin
            ea = exp_r.pop_front();
            check("read_addr", a_ra, ea);
          end
        end
        if (a_done && !done_prev) begin
          if (exp_res.size() == 0) check("unexpected_done", 1, 0);
          else begin
            r = exp_res.pop_front();
            check("err_cnt", a_err, r.cnt);
            check("first_err_addr", a_first, r.first);
            check("pass", a_pass, r.pass);
            check("latency", cyc - r.start_cyc, RUN_CYC);
            check("busy_at_done", a_busy, 0);
            check("writes_left_at_done", exp_w.size(), 0);
            check("reads_left_at_done", exp_r.size(), 0);
          end
        end
        done_prev = a_done;
      end
    end
  end

  initial begin : mon_b
    wr_t  e;
    res_t r;
    bit   done_prev;
    done_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_bw.delete();
        exp_bres.delete();
        done_prev = 1'b0;
      end else begin
        if (b_wce) begin
          if (exp_bw.size() == 0) check("b_unexpected_write", 1, 0);
          else begin
            e = exp_bw.pop_front();
            check("b_write_addr", b_wa, e.a);
            check("b_write_data", b_wd, e.d);
          end
        end
        if (b_done && !done_prev) begin
          if (exp_bres.size() == 0) check("b_unexpected_done", 1, 0);
          else begin
            r = exp_bres.pop_front();
            check("b_err_cnt", b_err, r.cnt);
            check("b_first_err_addr", b_first, r.first);
            check("b_pass", b_pass, r.pass);
            check("b_latency", cyc - r.start_cyc, RUN_CYC);
          end
        end
        done_prev = b_done;
      end
    end
  end

  // Expected outcome comes straight from the fault map: every faulty address in the window
  // mismatches once per pass, and reads go in ascending order.
  task automatic launch_a();
    int   sc;
    int   cnt;
    int   first;
    res_t r;
    @(posedge clk);
    #1 start = 1'b1;
    sc = cyc;
    @(posedge clk);
    #1 start = 1'b0;
    cnt   = 0;
    first = 0;
    for (int p = 0; p < PASSES; p++) begin
      for (int i = 0; i < DEPTH; i++) begin
        exp_w.push_back('{a: AW'(i), d: DW'(ref_pat(i, 0, p == 1))});
        exp_r.push_back(AW'(i));
        if (flip_a[i] != '0) begin
          if (cnt == 0) first = i;
          cnt++;
        end
      end
    end
    r.cnt       = (cnt > (2 ** CW - 1)) ? (2 ** CW - 1) : cnt;
    r.first     = first;
    r.pass      = (cnt == 0);
    r.start_cyc = sc;
    exp_res.push_back(r);
  endtask

  task automatic glitch_start();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done_a();
    int n;
    n = 0;
    while (!a_done && n < RUN_CYC + 16) begin
      @(negedge clk);
      n++;
    end
    if (!a_done) check("a_done_timeout", 0, 1);
    #1;
  endtask

  task automatic clear_faults();
    for (int i = 0; i < 1024; i++) flip_a[i] = '0;
  endtask

  task automatic check_zero_outputs(string name);
    check({name, "_ctrl"}, {a_busy, a_done, a_pass, a_wce, a_rce, a_err, a_first}, 0);
    check({name, "_bus"}, {a_wa, a_wd, a_ra}, 0);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d, expected < 20000", cyc);
    $fatal(1);
  end

  initial begin : stim
    int   sc;
    int   n;
    res_t r;
    for (int i = 0; i < 1024; i++) begin
      mem_a[i]  = '0;
      flip_a[i] = '0;
      mem_b[i]  = '0;
    end

    // Reset state, then a start that coincides with reset release must be ignored.
    repeat (3) @(negedge clk);
    check_zero_outputs("reset_state");
    start = 1'b1;
    @(posedge clk);
    #8 rst_n = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(negedge clk);
    check("start_at_reset_release_ignored", {a_busy, a_done, a_wce}, 0);

    // Clean run from idle; memory must then hold the final pattern everywhere.
    launch_a();
    wait_done_a();
    for (int i = 0; i < DEPTH; i++)
      check("mem_content", mem_a[i], DW'(ref_pat(i, 0, PASSES == 2)));

    // Stuck-at-1 on bit 3 at 0x005 (that bit is 0 in the pattern there).
    flip_a[5] = 18'h8;
    launch_a();
    wait_done_a();

    // Second fault at 0x1F0; a start pulse mid-run must be ignored.
    flip_a[10'h1F0] = 18'h8;
    launch_a();
    repeat (298) @(posedge clk);
    glitch_start();
    wait_done_a();

    // Start while done clears the previous (failing) results.
    clear_faults();
    launch_a();
    check("clear_on_restart", {a_err, a_first, a_done}, 0);
    check("busy_after_start", a_busy, 1);
    wait_done_a();

    // Reset during read 100 aborts at once.
    flip_a[7] = 18'h1;
    launch_a();
    repeat (DEPTH + 100) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_zero_outputs("reset_mid_run");
    clear_faults();
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    launch_a();
    wait_done_a();

    // Randomized fault maps, gaps and stray start pulses.
    for (int run = 0; run < 4; run++) begin
      clear_faults();
      n = $urandom_range(0, 5);
      for (int k = 0; k < n; k++)
        flip_a[$urandom_range(0, DEPTH - 1)] = DW'(1) << $urandom_range(0, DW - 1);
      repeat ($urandom_range(1, 20)) @(posedge clk);
      launch_a();
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(1, RUN_CYC - 8)) @(posedge clk);
        glitch_start();
      end
      wait_done_a();
    end

    // Offset window, 16-bit data, 8-bit counter: every read mismatches and the count saturates.
    @(posedge clk);
    #1 b_start = 1'b1;
    sc = cyc;
    @(posedge clk);
    #1 b_start = 1'b0;
    for (int p = 0; p < PASSES; p++)
      for (int i = 0; i < DEPTH; i++)
        exp_bw.push_back('{a: AW'(BBASE + i), d: DW'(BDW'(ref_pat(BBASE + i, 1, p == 1)))});
    r.cnt       = 255;
    r.first     = BBASE;
    r.pass      = 1'b0;
    r.start_cyc = sc;
    exp_bres.push_back(r);
    n = 0;
    while (!b_done && n < RUN_CYC + 16) begin
      @(negedge clk);
      n++;
    end
    if (!b_done) check("b_done_timeout", 0, 1);
    #1;
    check("b_writes_left", exp_bw.size(), 0);
    check("a_results_left", exp_res.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
